// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions: block width, mode encodings, the
//                pipeline stage record and the byte/row/column index helpers
//                used to place state bytes in the 128-bit vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BLOCK_W  = 128;
  localparam int AES_NB_BYTES = AES_BLOCK_W / 8;

  // Direction tag carried with every block.
  localparam logic MODE_ENC = 1'b0;  // ShiftRows
  localparam logic MODE_DEC = 1'b1;  // InvShiftRows

  // One pipeline slot: direction tag plus the permuted state.
  typedef struct packed {
    logic                   mode;
    logic [AES_BLOCK_W-1:0] data;
  } stage_t;

  // Byte k of the state sits in row k%4, column k/4 (column-major order).
  function automatic int byte_row(input int k);
    return k % 4;
  endfunction

  function automatic int byte_col(input int k);
    return k / 4;
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  // Byte 0 occupies the most significant byte of the vector.
  function automatic int byte_msb(input int k);
    return AES_BLOCK_W - 1 - 8 * k;
  endfunction

  // Source column for output position (r, c). Row r rotates left by r
  // columns when encrypting and right by r columns when decrypting; the +4
  // keeps the decrypt difference non-negative before the modulo.
  function automatic int src_col(input logic dec, input int r, input int c);
    if (dec == MODE_DEC) begin
      return (c - r + 4) % 4;
    end
    return (c + r) % 4;
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_shift_rows_comb.sv
`default_nettype none
// ============================================================================
//  Module      : aes_shift_rows_comb
//  Description : Purely combinational AES ShiftRows / InvShiftRows byte
//                permutation. Shared by the pipelined wrapper and the round
//                datapath.
//  Ports       : mode      in   0 = ShiftRows, 1 = InvShiftRows
//                in_block  in   128-bit AES state
//                out_block out  permuted state
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_shift_rows_comb
  import aes_pkg::*;
(
  input  logic                   mode,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic [AES_BLOCK_W-1:0] out_block
);

  // Every output byte is a fixed two-way choice between its encrypt source
  // and its decrypt source, so the permutation collapses to 16 byte muxes
  // whose wiring is resolved at elaboration time.
  for (genvar k = 0; k < AES_NB_BYTES; k++) begin : g_byte
    localparam int ROW     = byte_row(k);
    localparam int COL     = byte_col(k);
    localparam int ENC_SRC = byte_idx(ROW, src_col(MODE_ENC, ROW, COL));
    localparam int DEC_SRC = byte_idx(ROW, src_col(MODE_DEC, ROW, COL));
    localparam int DST_MSB = byte_msb(k);
    localparam int ENC_MSB = byte_msb(ENC_SRC);
    localparam int DEC_MSB = byte_msb(DEC_SRC);

    assign out_block[DST_MSB -: 8] = (mode == MODE_DEC) ? in_block[DEC_MSB -: 8]
                                                        : in_block[ENC_MSB -: 8];
  end

endmodule : aes_shift_rows_comb
`default_nettype wire

// File: rtl/aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : aes_shift_rows_pipe
//  Description : Valid/ready pipelined AES ShiftRows / InvShiftRows. The
//                permutation is applied ahead of the first register, then the
//                block travels through STAGES elastic stages with its mode
//                tag. Counts accepted input blocks.
//  Parameters  : STAGES  number of register stages (1..4)
//                CNT_W   width of the accepted-block counter
//  Ports       : clk       in   clock, rising edge
//                rst_n     in   asynchronous active-low reset
//                flush     in   synchronous clear of all in-flight blocks
//                in_valid  in   block offered
//                in_ready  out  block accepted when in_valid && in_ready
//                in_mode   in   0 = ShiftRows, 1 = InvShiftRows
//                block     in   128-bit AES state
//                out_valid out  result present
//                out_ready in   downstream accepts when out_valid && out_ready
//                new_block out  permuted state
//                out_mode  out  mode tag travelling with the block
//                blk_cnt   out  count of accepted input blocks (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [AES_BLOCK_W-1:0] block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] new_block,
  output logic                   out_mode,
  output logic [CNT_W-1:0]       blk_cnt
);

  logic [AES_BLOCK_W-1:0] perm_block;
  logic [STAGES-1:0]      advance;
  logic                   accept;

  logic [STAGES-1:0]      valid_q;
  logic [STAGES-1:0]      valid_d;
  stage_t                 stage_q [STAGES];
  stage_t                 stage_d [STAGES];
  logic [CNT_W-1:0]       blk_cnt_q;
  logic [CNT_W-1:0]       blk_cnt_d;

  aes_shift_rows_comb u_perm (
    .mode      (in_mode),
    .in_block  (block),
    .out_block (perm_block)
  );

  // Stage i may advance when it is empty or stage i+1 advances; the last
  // stage advances when empty or drained. Unrolled, stage i advances when any
  // stage from i to the output holds a bubble, or out_ready is high. Walking
  // from the output end with an accumulated bubble flag avoids a
  // self-referencing vector.
  always_comb begin
    logic bubble;
    bubble  = 1'b0;
    advance = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      bubble     = bubble | ~valid_q[i];
      advance[i] = bubble | out_ready;
    end
  end

  assign in_ready = !flush && advance[0];
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end

    if (advance[0]) begin
      valid_d[0]      = accept;
      stage_d[0].mode = in_mode;
      stage_d[0].data = perm_block;
    end

    for (int i = 1; i < STAGES; i++) begin
      if (advance[i]) begin
        valid_d[i] = valid_q[i-1];
        stage_d[i] = stage_q[i-1];
      end
    end

    // Flush only kills the valid bits; the data left behind is don't-care.
    if (flush) begin
      valid_d = '0;
    end

    blk_cnt_d = blk_cnt_q + CNT_W'(accept);
  end

  // Every stage is cleared on reset so the output stage reads zero and the
  // interior stages hold a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      blk_cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      blk_cnt_q <= blk_cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign new_block = stage_q[STAGES-1].data;
  assign out_mode  = stage_q[STAGES-1].mode;
  assign blk_cnt   = blk_cnt_q;

endmodule : aes_shift_rows_pipe
`default_nettype wire

// File: tb/tb_aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_shift_rows_pipe
//  Description : Self-checking bench for aes_shift_rows_pipe. A scoreboard
//                fed by an array-based ShiftRows model tracks every accepted
//                block; directed vectors, random streams with backpressure,
//                flush, reset and parameter variants are exercised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_shift_rows_pipe;

  localparam logic [127:0] VEC     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_ENC = 128'h0055aaff4499ee3388dd2277cc1166bb;
  localparam logic [127:0] VEC_DEC = 128'h00ddaa774411eebb885522ffcc996633;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] new_block;
  logic         out_mode;
  logic [15:0]  blk_cnt;

  // Small variants: STAGES = 1 and 4 with a 4-bit counter.
  logic         s_valid;
  logic         s_mode;
  logic [127:0] s_block;
  logic         s1_ready, s1_ovalid, s1_omode;
  logic [127:0] s1_nb;
  logic [3:0]   s1_cnt;
  logic         s4_ready, s4_ovalid, s4_omode;
  logic [127:0] s4_nb;
  logic [3:0]   s4_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic         mode;
    logic [127:0] data;
  } exp_t;
  exp_t exp_q[$];

  aes_shift_rows_pipe #(.STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_mode(in_mode), .block(block),
    .out_valid(out_valid), .out_ready(out_ready), .new_block(new_block),
    .out_mode(out_mode), .blk_cnt(blk_cnt)
  );

  aes_shift_rows_pipe #(.STAGES(1), .CNT_W(4)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(s_valid),
    .in_ready(s1_ready), .in_mode(s_mode), .block(s_block),
    .out_valid(s1_ovalid), .out_ready(1'b1), .new_block(s1_nb),
    .out_mode(s1_omode), .blk_cnt(s1_cnt)
  );

  aes_shift_rows_pipe #(.STAGES(4), .CNT_W(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(s_valid),
    .in_ready(s4_ready), .in_mode(s_mode), .block(s_block),
    .out_valid(s4_ovalid), .out_ready(1'b1), .new_block(s4_nb),
    .out_mode(s4_omode), .blk_cnt(s4_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: lay the bytes out as a 4x4 state and rotate each row.
  function automatic logic [127:0] ref_shift(input logic dec, input logic [127:0] b);
    logic [7:0]   s [4][4];
    logic [7:0]   o [4][4];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) s[k % 4][k / 4] = b[127 - 8 * k -: 8];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        o[row][col] = dec ? s[row][(col - row + 4) % 4] : s[row][(col + row) % 4];
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = o[k % 4][k / 4];
    return r;
  endfunction

  // Scoreboard and hold monitor for the main instance.
  logic         prev_hold, prev_flush, prev_mode;
  logic [127:0] prev_nb;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_hold  = 1'b0;
      prev_flush = 1'b0;
    end else begin
      if (prev_hold && !prev_flush) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", new_block, prev_nb);
        check_eq("hold_mode", out_mode, prev_mode);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_when_empty", out_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("sb_data", new_block, e.data);
          check_eq("sb_mode", out_mode, e.mode);
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back('{in_mode, ref_shift(in_mode, block)});
      prev_hold  = out_valid && !out_ready;
      prev_flush = flush;
      prev_nb    = new_block;
      prev_mode  = out_mode;
    end
  end

  task automatic send_one(input logic mode, input logic [127:0] blk,
                          output int lat, output logic [127:0] got, output logic got_mode);
    logic acc;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = mode; block = blk; out_ready = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) begin @(posedge clk); #1; end
    end
    if (!acc) check_eq("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    got      = new_block;
    got_mode = out_mode;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    check_eq("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check_eq("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, lat1, lat4;
    logic [127:0] got, enc_out, nb1, nb4;
    logic         gmode, acc;
    logic [15:0]  cnt0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0; block = '0;
    out_ready = 1'b0; s_valid = 1'b0; s_mode = 1'b0; s_block = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_new_block", new_block, 0);
    check_eq("rst_out_mode", out_mode, 0);
    check_eq("rst_blk_cnt", blk_cnt, 0);
    rst_n = 1'b1;

    // Directed encrypt / decrypt / round trip.
    send_one(1'b0, VEC, lat, got, gmode);
    check_eq("enc_latency", lat, 2);
    check_eq("enc_data", got, VEC_ENC);
    check_eq("enc_mode", gmode, 0);
    enc_out = got;
    send_one(1'b1, VEC, lat, got, gmode);
    check_eq("dec_latency", lat, 2);
    check_eq("dec_data", got, VEC_DEC);
    check_eq("dec_mode", gmode, 1);
    send_one(1'b1, enc_out, lat, got, gmode);
    check_eq("roundtrip", got, VEC);
    drain();

    // Random stream, alternating modes, 50% backpressure.
    cnt0 = blk_cnt;
    for (int n = 0; n < 96; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_mode  = n[0];
      block    = {$urandom(), $urandom(), $urandom(), $urandom()};
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = in_ready;
        if (!acc) begin @(posedge clk); #1; end
      end
      if (!acc) check_eq("rand_accept", in_ready, 1);
    end
    drain();
    check_eq("rand_count", 16'(blk_cnt - cnt0), 96);

    // Full pipe with 10 cycles of backpressure, then full throughput.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (4) begin
      block = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_mode = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (8) begin
      block = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("thru_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    drain();

    // Flush with a full pipe and in_valid held high.
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (4) begin
      block = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", in_ready, 0);
    cnt0 = blk_cnt;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_out_valid", out_valid, 0);
    check_eq("flush_blk_cnt", blk_cnt, cnt0);
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      block = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_new_block", new_block, 0);
    check_eq("arst_out_mode", out_mode, 0);
    check_eq("arst_blk_cnt", blk_cnt, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_one(1'b0, VEC, lat, got, gmode);
    check_eq("post_rst_latency", lat, 2);
    check_eq("post_rst_data", got, VEC_ENC);
    drain();

    // STAGES = 1 and STAGES = 4 variants, 4-bit counter wrap.
    @(posedge clk); #1;
    s_valid = 1'b1; s_mode = 1'b0; s_block = VEC;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat1 = 0; lat4 = 0; nb1 = '0; nb4 = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (s1_ovalid && lat1 == 0) begin lat1 = cyc; nb1 = s1_nb; end
      if (s4_ovalid && lat4 == 0) begin lat4 = cyc; nb4 = s4_nb; end
      @(posedge clk); #1;
    end
    check_eq("s1_latency", lat1, 1);
    check_eq("s4_latency", lat4, 4);
    check_eq("s1_data", nb1, VEC_ENC);
    check_eq("s4_data", nb4, VEC_ENC);
    s_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      s_mode  = n[0];
      s_block = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check_eq("s1_cnt_wrap", s1_cnt, 1);
    check_eq("s4_cnt_wrap", s4_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_aes_shift_rows_pipe
`default_nettype wire

// File: doc/aes_shift_rows_pipe.md
AES_SHIFT_ROWS_PIPE -- requirements
Module: aes_shift_rows_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 2, number of register stages; legal range 1..4.
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-block counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all in-flight blocks.
REQ-006 SHALL have port in_valid  input  1  block offered.
REQ-007 SHALL have port in_ready  output  1  block accepted when in_valid&&in_ready.
REQ-008 SHALL have port in_mode  input  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt).
REQ-009 SHALL have port block  input  128  AES state.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when out_valid&&out_ready.
REQ-012 SHALL have port new_block  output  128  permuted state.
REQ-013 SHALL have port out_mode  output  1  in_mode tag travelling with the block.
REQ-014 SHALL have port blk_cnt  output  CNT_W  count of accepted input blocks.

Function
REQ-015 SHALL map byte k = block[127-8k -: 8], row r = k%4, column c = k/4.
REQ-016 SHALL compute ShiftRows as out[r][c] = in[r][(c+r)%4] and InvShiftRows as out[r][c] = in[r][(c-r)%4]; permutation applied before the first stage register.
REQ-017 SHALL hold STAGES valid-tagged stages, each storing {mode, 128-bit data}.
REQ-018 SHALL advance stage i when stage i is empty or stage i+1 advances; the last stage advances when empty or out_ready=1.
REQ-019 SHALL drive in_ready = !flush && (first stage empty || first stage advances); in_ready may depend combinationally on out_ready.
REQ-020 SHALL give a latency of exactly STAGES cycles from acceptance to out_valid with no backpressure; throughput one block per cycle.
REQ-021 SHALL hold new_block, out_mode and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL never drop, duplicate or reorder blocks; mode SHALL be taken per block, so mixed-mode streams are legal.
REQ-023 SHALL increment blk_cnt by 1 on each accepted block, wrapping from 2^CNT_W-1 to 0.
REQ-024 flush=1 SHALL clear all stage valid bits on the next edge, block acceptance that cycle (flush wins over in_valid), and leave blk_cnt unchanged.
REQ-025 Accept and emit in the same cycle with a full pipe SHALL be lossless (full throughput under out_ready=1).
REQ-026 new_block and out_mode SHALL be don't-care when out_valid=0.

Reset
REQ-027 rst_n low SHALL immediately clear all stage valid bits, out_valid=0, blk_cnt=0, new_block=0, out_mode=0.
REQ-028 Reset mid-operation SHALL discard in-flight blocks; the first accepted block after release SHALL emerge after exactly STAGES cycles.
REQ-029 Data registers other than the output stage need not be reset.

Structure
REQ-030 Shared package aes_pkg SHALL hold AES_BLOCK_W=128, the byte/row/column index helpers and the MODE_ENC=0/MODE_DEC=1 constants.
REQ-031 Sub-module aes_shift_rows_comb (mode input, 128-bit in/out, purely combinational) SHALL implement REQ-015/016 and be reused by the round datapath.

Verification
REQ-032 mode=0, block=00112233445566778899aabbccddeeff -> new_block=0055aaff4499ee3388dd2277cc1166bb, out_mode=0, after STAGES cycles.
REQ-033 mode=1, same block -> new_block=00ddaa774411eebb885522ffcc996633, out_mode=1; feeding ShiftRows output back with mode=1 returns the original block.
REQ-034 96 random blocks, alternating modes, out_ready random at 50% -> outputs in order, each matching a reference model, blk_cnt=96, no holds violated.
REQ-035 Pipe full, out_ready=0 for 10 cycles -> in_ready=0 and output stable; then out_ready=1 with in_valid=1 continuous -> one block per cycle, none lost.
REQ-036 flush asserted with in_valid=1 and pipe full -> in_ready=0 that cycle, out_valid=0 next cycle, blk_cnt unchanged; rst_n pulsed mid-stream -> all outputs zero immediately.
REQ-037 CNT_W=4, 17 accepted blocks -> blk_cnt=1; repeat REQ-032 for STAGES=1 and STAGES=4 -> latency 1 and 4 cycles.
